// File: rtl/branch_predictor_bht_pkg.sv
// bp_pkg: shared types and counter arithmetic for the branch history table.
package bp_pkg;
    localparam int ENTRIES = 64;
    typedef logic [$clog2(ENTRIES)-1:0] idx_t;
    // Weakly-not-taken value: just below the taken threshold.
    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction
    function automatic int sat_step(input int cnt, input logic taken, input int cnt_w);
        int mx;
        mx = (1 << cnt_w) - 1;
        return taken ? (cnt == mx ? cnt : cnt + 1) : (cnt == 0 ? 0 : cnt - 1);
    endfunction
endpackage

// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if: prediction and resolved-update signals between fetch/execute and the BHT.
interface branch_predictor_bht_if #(
    parameter int PC_W  = 32,
    parameter int IDX_W = 6,
    parameter int GHR_W = 6
);
    logic [PC_W-1:0]  i_pred_pc;
    logic             o_pred_taken;
    logic [IDX_W-1:0] o_pred_idx;
    logic             i_upd_valid;
    logic [IDX_W-1:0] i_upd_idx;
    logic             i_upd_taken;
    logic [GHR_W-1:0] o_ghr;
    modport master (
        output i_pred_pc, i_upd_valid, i_upd_idx, i_upd_taken,
        input  o_pred_taken, o_pred_idx, o_ghr
    );
    modport slave (
        input  i_pred_pc, i_upd_valid, i_upd_idx, i_upd_taken,
        output o_pred_taken, o_pred_idx, o_ghr
    );
endinterface

// File: rtl/branch_predictor_bht_sat_counter.sv
// bp_sat_counter: one saturating up/down counter of the history table.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_taken,
    output logic [CNT_W-1:0] o_cnt
);
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            o_cnt <= CNT_W'(cnt_init(CNT_W));
        else if (i_en)
            o_cnt <= CNT_W'(sat_step(int'(o_cnt), i_taken, CNT_W));
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: PC-indexed table of saturating counters with optional gshare hashing.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int GSHARE  = 1,
    parameter int GHR_W   = 6
) (
    input  logic i_clk,
    input  logic i_rst,
    branch_predictor_bht_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    logic [GHR_W-1:0] ghr;
    logic [CNT_W-1:0] cnt [ENTRIES];
    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] idx;
    logic             unused_pc;
    assign unused_pc = ^{bus.i_pred_pc[PC_W-1:IDX_W+2], bus.i_pred_pc[1:0]};
    assign pc_idx = bus.i_pred_pc[IDX_W+1:2];
    assign idx = (GSHARE != 0) ? (pc_idx ^ IDX_W'(ghr)) : pc_idx;
    // History only advances on resolved branches; newest outcome enters at the LSB.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            ghr <= '0;
        else if (GSHARE != 0 && bus.i_upd_valid)
            ghr <= (ghr << 1) | GHR_W'(bus.i_upd_taken);
    for (genvar k = 0; k < ENTRIES; k++) begin : g_cnt
        bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (bus.i_upd_valid && bus.i_upd_idx == IDX_W'(k)),
            .i_taken(bus.i_upd_taken),
            .o_cnt  (cnt[k])
        );
    end
    assign bus.o_pred_taken = cnt[idx][CNT_W-1];
    assign bus.o_pred_idx   = idx;
    assign bus.o_ghr        = ghr;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: checks three BHT configurations against a counter-array model.
module tb_branch_predictor_bht;
    logic clk = 0;
    logic rst = 0;
    always #5 clk = ~clk;
    branch_predictor_bht_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) bus_a ();
    branch_predictor_bht_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) bus_g ();
    branch_predictor_bht_if #(.PC_W(32), .IDX_W(6), .GHR_W(6)) bus_w ();
    branch_predictor_bht #(.GSHARE(0), .CNT_W(2)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    branch_predictor_bht #(.GSHARE(1), .CNT_W(2)) dut_g (.i_clk(clk), .i_rst(rst), .bus(bus_g));
    branch_predictor_bht #(.GSHARE(0), .CNT_W(3)) dut_w (.i_clk(clk), .i_rst(rst), .bus(bus_w));
    int m_a [64];
    int m_g [64];
    int m_w [64];
    int m_ghr;
    int n_pass = 0;
    int n_total = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask
    function automatic int sat(input int c, input bit t, input int mx);
        return t ? (c < mx ? c + 1 : c) : (c > 0 ? c - 1 : 0);
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_a[i] = 1;
            m_g[i] = 1;
            m_w[i] = 3;
        end
        m_ghr = 0;
    endtask
    task automatic model_upd(input bit t, input int i);
        m_a[i] = sat(m_a[i], t, 3);
        m_g[i] = sat(m_g[i], t, 3);
        m_w[i] = sat(m_w[i], t, 7);
        m_ghr = (m_ghr * 2 + int'(t)) % 64;
    endtask
    task automatic drive(input logic [31:0] pc, input bit v, input int i, input bit t);
        bus_a.i_pred_pc = pc; bus_a.i_upd_valid = v; bus_a.i_upd_idx = 6'(i); bus_a.i_upd_taken = t;
        bus_g.i_pred_pc = pc; bus_g.i_upd_valid = v; bus_g.i_upd_idx = 6'(i); bus_g.i_upd_taken = t;
        bus_w.i_pred_pc = pc; bus_w.i_upd_valid = v; bus_w.i_upd_idx = 6'(i); bus_w.i_upd_taken = t;
    endtask
    task automatic check_now(input logic [31:0] pc);
        int p;
        int ig;
        p = int'((pc >> 2) & 32'h3f);
        ig = p ^ m_ghr;
        chk("a_idx", 32'(bus_a.o_pred_idx), 32'(p));
        chk("a_taken", 32'(bus_a.o_pred_taken), 32'(m_a[p] >= 2));
        chk("a_ghr", 32'(bus_a.o_ghr), 32'd0);
        chk("g_idx", 32'(bus_g.o_pred_idx), 32'(ig));
        chk("g_taken", 32'(bus_g.o_pred_taken), 32'(m_g[ig] >= 2));
        chk("g_ghr", 32'(bus_g.o_ghr), 32'(m_ghr));
        chk("w_idx", 32'(bus_w.o_pred_idx), 32'(p));
        chk("w_taken", 32'(bus_w.o_pred_taken), 32'(m_w[p] >= 4));
    endtask
    task automatic probe(input logic [31:0] pc);
        drive(pc, 0, 0, 0);
        #1 check_now(pc);
    endtask
    task automatic step(input logic [31:0] pc, input bit v, input int i, input bit t);
        @(negedge clk);
        drive(pc, v, i, t);
        #1 check_now(pc);
        @(posedge clk);
        if (v) model_upd(t, i);
        #1 drive(pc, 0, 0, 0);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1;
        model_reset();
        #1;
        @(negedge clk) rst = 0;
    endtask
    initial begin
        bit up_exp [3] = '{1, 1, 1};
        bit dn_exp [4] = '{1, 0, 0, 0};
        drive(0, 0, 0, 0);
        #1 rst = 1;
        model_reset();
        #11 check_now(0);
        @(negedge clk) rst = 0;
        for (int pc = 0; pc <= 'hfc; pc += 4) probe(32'(pc));
        for (int n = 0; n < 3; n++) begin
            step(32'h14, 1, 5, 1);
            probe(32'h14);
            chk("sat_up", 32'(bus_a.o_pred_taken), 32'(up_exp[n]));
        end
        for (int n = 0; n < 4; n++) begin
            step(32'h14, 1, 5, 0);
            probe(32'h14);
            chk("sat_dn", 32'(bus_a.o_pred_taken), 32'(dn_exp[n]));
        end
        do_reset();
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        chk("ghr_101", 32'(bus_g.o_ghr), 32'b000101);
        probe(32'h40);
        chk("hash_21", 32'(bus_g.o_pred_idx), 32'd21);
        do_reset();
        @(negedge clk);
        drive(32'h24, 1, 9, 1);
        #1 chk("haz_before", 32'(bus_a.o_pred_taken), 32'd0);
        check_now(32'h24);
        @(posedge clk);
        model_upd(1, 9);
        #1 drive(32'h24, 0, 0, 0);
        #1 chk("haz_after", 32'(bus_a.o_pred_taken), 32'd1);
        check_now(32'h24);
        do_reset();
        probe(0);
        chk("w_reset", 32'(bus_w.o_pred_taken), 32'd0);
        step(0, 1, 0, 1);
        probe(0);
        chk("w_flip", 32'(bus_w.o_pred_taken), 32'd1);
        repeat (4) step(0, 1, 0, 1);
        repeat (3) step(0, 1, 0, 0);
        probe(0);
        chk("w_sat_hold", 32'(bus_w.o_pred_taken), 32'd1);
        step(0, 1, 0, 0);
        probe(0);
        chk("w_sat_drop", 32'(bus_w.o_pred_taken), 32'd0);
        do_reset();
        repeat (400) step($urandom & 32'hfc, $urandom_range(0, 3) != 0,
                          int'($urandom_range(0, 7)), 1'($urandom));
        do_reset();
        step(32'h14, 1, 5, 1);
        step(32'h14, 1, 5, 1);
        step(0, 1, 0, 1);
        #2 drive(32'h14, 1, 5, 1);
        rst = 1;
        model_reset();
        #1 chk("arst_ghr", 32'(bus_g.o_ghr), 32'd0);
        chk("arst_taken", 32'(bus_a.o_pred_taken), 32'd0);
        check_now(32'h14);
        @(posedge clk);
        #1 check_now(32'h14);
        for (int pc = 0; pc <= 'hfc; pc += 4) probe(32'(pc));
        @(negedge clk) rst = 0;
        probe(32'h14);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
